// File: rtl/minterm_pkg.sv
// Shared widths and FSM state encoding for the minterm scanner.
// No ports: package only.
package minterm_pkg;

   localparam int unsigned N_IN  = 4;   // function inputs
   localparam int unsigned N_MT  = 16;  // minterms = 2**N_IN
   localparam int unsigned CNT_W = 5;   // holds 0..16 without wrap

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      EMIT = 2'd2,
      FIN  = 2'd3
   } state_e;

endpackage

// File: rtl/minterm_scanner_if.sv
// Bundles the scanner's control, function-under-test and minterm-stream signals.
// master: scanner side (drives vec_out, status, stream, tt, count).
// slave : environment side (drives start, f_in, m_ready).
interface minterm_scanner_if;
   import minterm_pkg::*;

   logic             start;
   logic [N_IN-1:0]  vec_out;
   logic             f_in;
   logic             busy;
   logic             m_valid;
   logic             m_ready;
   logic [N_IN-1:0]  m_index;
   logic             m_last;
   logic             done;
   logic [N_MT-1:0]  tt;
   logic [CNT_W-1:0] count;

   modport master (
      input  start, f_in, m_ready,
      output vec_out, busy, m_valid, m_index, m_last, done, tt, count
   );

   modport slave (
      output start, f_in, m_ready,
      input  vec_out, busy, m_valid, m_index, m_last, done, tt, count
   );

endinterface

// File: rtl/lsb_encoder16.sv
// Combinational lowest-set-bit encoder, 16 -> 4, with an any-bit-set flag.
// Ports: vec_i (16-bit mask), idx_o (index of lowest set bit, 0 if none), any_o.
module lsb_encoder16
   import minterm_pkg::*;
(
   input  logic [N_MT-1:0] vec_i,
   output logic [N_IN-1:0] idx_o,
   output logic            any_o
);

   // Scan from the top so the lowest set bit is the last one written.
   always_comb begin
      idx_o = '0;
      for (int i = N_MT - 1; i >= 0; i--) begin
         if (vec_i[i]) idx_o = N_IN'(i);
      end
   end

   assign any_o = |vec_i;

endmodule

// File: rtl/minterm_scanner.sv
// Sweeps a 4-input combinational function through all 16 vectors, captures its
// truth table and true-minterm count, then streams the true minterm indices in
// ascending order over a valid/ready handshake.
// Ports: clk, rst (sync, active-high), bus (minterm_scanner_if.master).
module minterm_scanner
   import minterm_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   minterm_scanner_if.master        bus
);

   state_e           state_q, state_d;
   logic [N_IN-1:0]  vec_q, vec_d;
   logic [N_MT-1:0]  tt_q, tt_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [N_MT-1:0]  rem_q, rem_d;
   logic             m_valid_q, m_valid_d;
   logic [N_IN-1:0]  m_index_q, m_index_d;
   logic             m_last_q, m_last_d;
   logic             done_q, done_d;
   logic             busy_q, busy_d;

   logic [CNT_W-1:0] cnt_next;
   logic [N_IN-1:0]  enc_idx;
   logic             enc_any;

   // Lowest remaining minterm, looked up on the next-state mask so the
   // registered index is ready the cycle the mask changes.
   lsb_encoder16 u_enc (
      .vec_i (rem_d),
      .idx_o (enc_idx),
      .any_o (enc_any)
   );

   assign cnt_next = cnt_q + CNT_W'(bus.f_in);

   // Next-state and datapath update.
   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      tt_d    = tt_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;

      unique case (state_q)
         IDLE: begin
            vec_d = '0;
            if (bus.start) begin
               tt_d    = '0;
               cnt_d   = '0;
               rem_d   = '0;
               state_d = SCAN;
            end
         end
         SCAN: begin
            tt_d[vec_q] = bus.f_in;
            cnt_d       = cnt_next;
            vec_d       = vec_q + N_IN'(1);   // wraps to 0 after the last vector
            if (vec_q == N_IN'(N_MT - 1)) begin
               rem_d   = tt_d;
               state_d = (cnt_next != '0) ? EMIT : FIN;
            end
         end
         EMIT: begin
            if (m_valid_q && bus.m_ready) begin
               rem_d = rem_q & ~(N_MT'(1) << m_index_q);
               if (m_last_q) state_d = FIN;
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Registered stream and status outputs, derived from next state.
   always_comb begin
      m_valid_d = (state_d == EMIT);
      m_index_d = enc_idx;
      // Exactly one bit left: nonzero and clearing the lowest bit leaves zero.
      m_last_d  = enc_any && ((rem_d & (rem_d - N_MT'(1))) == '0);
      done_d    = (state_d == FIN);
      busy_d    = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         vec_q     <= '0;
         tt_q      <= '0;
         cnt_q     <= '0;
         rem_q     <= '0;
         m_valid_q <= 1'b0;
         m_index_q <= '0;
         m_last_q  <= 1'b0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         vec_q     <= vec_d;
         tt_q      <= tt_d;
         cnt_q     <= cnt_d;
         rem_q     <= rem_d;
         m_valid_q <= m_valid_d;
         m_index_q <= m_index_d;
         m_last_q  <= m_last_d;
         done_q    <= done_d;
         busy_q    <= busy_d;
      end
   end

   assign bus.vec_out = vec_q;
   assign bus.tt      = tt_q;
   assign bus.count   = cnt_q;
   assign bus.m_valid = m_valid_q;
   assign bus.m_index = m_index_q;
   assign bus.m_last  = m_last_q;
   assign bus.done    = done_q;
   assign bus.busy    = busy_q;

endmodule

// File: doc/minterm_scanner.md
# minterm_scanner

Sequential truth-table extractor, the inverse of our minterm-list combinational function blocks. On `start` it sweeps a 4-bit input vector through all 16 values and drives them into an external combinational function under test. It samples the 1-bit result into a 16-bit truth table, then streams the indices of all true minterms in ascending order over a valid/ready handshake. It sits beside our 4-input function modules as a self-check and characterisation engine.

## Interface
Parameters:
- none; width fixed at 4 inputs / 16 minterms.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  begin a scan; honoured only in IDLE.
- `vec_out`  out  4  vector driven to the function under test, `{a,b,c,d}`, with `a` as MSB.
- `f_in`  in  1  function output, combinational from `vec_out`.
- `busy`  out  1  high in any state other than IDLE.
- `m_valid`  out  1  minterm index available.
- `m_ready`  in  1  consumer accepts the index.
- `m_index`  out  4  current minterm index.
- `m_last`  out  1  qualifies `m_valid`; marks the final minterm.
- `done`  out  1  one-cycle pulse at the end of an operation.
- `tt`  out  16  captured truth table; bit i = f(i). Held until the next scan starts.
- `count`  out  5  number of true minterms, 0..16.

## Operation
- States: IDLE, SCAN, EMIT, FIN.
- IDLE:
  - `vec_out` = 0.
  - If `start` is asserted, clear `tt` and `count`, then go to SCAN.
- SCAN:
  - Internal counter `i` runs 0..15, with `vec_out` = `i`.
  - Each cycle, `tt[i]` <= `f_in` and `count` += `f_in`.
  - After `i` = 15: if the final count is > 0, go to EMIT; otherwise go to FIN.
- EMIT:
  - Remaining mask `rem` is loaded from `tt` on entry.
  - `m_index` = lowest set bit of `rem`.
  - `m_valid` = 1.
  - `m_last` = (popcount(`rem`) == 1).
  - On `m_valid && m_ready`, clear that bit of `rem`.
  - If `m_last` was set, go to FIN.
  - Throughput is one index per cycle when `m_ready` is held high.
  - `m_index` and `m_last` are stable while `m_valid && !m_ready`.
- FIN: `done` = 1 for exactly one cycle, then go to IDLE.
- `start` outside IDLE is ignored; there is no queueing.
- `f_in` is don't-care outside SCAN.
- Reset values:
  - state = IDLE.
  - `vec_out`, `tt`, `count`, `m_index` = 0.
  - `m_valid`, `m_last`, `done`, `busy` = 0.
- Reset asserted mid-SCAN or mid-EMIT aborts the operation immediately:
  - No `done` pulse.
  - Any remaining minterms are discarded.
- `count` width is 5 bits, so all 16 minterms true yields 16 without wrap.

## Timing
- `start` is sampled high at edge t: SCAN occupies cycles t+1..t+16, with `vec_out` = 0..15 in order.
- `tt` and `count` are final from cycle t+17.
- If minterms exist: `m_valid` first rises in cycle t+17.
- After the handshake on `m_last` in cycle k, `done` is high in cycle k+1 and the block is IDLE (`busy` = 0) in cycle k+2.
- Zero minterms: `done` is high in cycle t+17 and `m_valid` is never asserted.
- With `m_ready` tied high and N minterms: `done` falls in cycle t+17+N.
- `start` is accepted again in the cycle after `done` (block back in IDLE).

## Structure
- Package `minterm_pkg`:
  - State enum (IDLE, SCAN, EMIT, FIN).
  - Constants `N_IN` = 4, `N_MT` = 16, `CNT_W` = 5.
- Sub-module `lsb_encoder16`:
  - Combinational 16-to-4 lowest-set-bit encoder plus `any` flag.
  - Used in EMIT to derive `m_index`.
- Popcount-equals-one for `m_last` is computed as `rem & (rem-1) == 0`.

## Test plan
- `f_in` = f(v) true on {5,7,12,13,15}, `m_ready` = 1 → `tt` = 0xB0A0, `count` = 5, indices 5,7,12,13,15, with `m_last` on 15; `done` in cycle t+22.
- f = (~c&d)|(b&~c) → `tt` = 0x3232, `count` = 6, stream 1,4,5,9,12,13.
- `f_in` = 0 → `count` = 0, no `m_valid`, `done` in cycle t+17; `f_in` = 1 → `count` = 16, stream 0..15, `tt` = 0xFFFF.
- Backpressure: minterms {5,7,12,13,15} with `m_ready` toggling 1010… → same order, no drops or duplicates, `m_index` stable while stalled.
- `start` pulsed during SCAN and EMIT → ignored, result unchanged.
- `rst` during EMIT after 2 indices → all outputs 0, no `done`; a following `start` produces a full correct stream.
